// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation codes and control FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Sign correction of raw magnitude results: negates the full product for MULT,
// and the quotient/remainder halves independently for DIV.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] raw,
  input  logic               neg_q,
  input  logic               neg_r,
  input  logic [1:0]         op,
  output logic [2*WIDTH-1:0] fixed
);

  always_comb begin
    fixed = raw;
    if (op == OP_MULT) begin
      if (neg_q) fixed = -raw;
    end else if (op == OP_DIV) begin
      if (neg_q) fixed[WIDTH-1:0] = -raw[WIDTH-1:0];
      if (neg_r) fixed[2*WIDTH-1:WIDTH] = -raw[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit with internal HI/LO.
// One shared 2*WIDTH accumulator: {hi, lo} for multiply, {remainder, quotient} for divide.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic sgn);
    if (sgn && v[WIDTH-1]) return WIDTH'(-v);
    return WIDTH'(v);
  endfunction

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic               neg_q, neg_r, zero_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, fixed;
  logic [WIDTH-1:0]   opb;
  logic               accept, sgn_op;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_rem;
  logic               div_ge;

  assign accept = (state == IDLE) && start;
  assign sgn_op = ~op[0];
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (op[1] && (b == '0)) ? FIN : RUN;
      RUN:     if (cnt == LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: shift-add for multiply, trial subtract for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, opb});
    div_rem   = WIDTH'(div_shift - {1'b0, opb});
    acc_nxt   = {mul_sum, acc[WIDTH-1:1]};
    if (op_q[1]) begin
      acc_nxt = div_ge ? {div_rem, acc[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .raw   (acc),
    .neg_q (neg_q),
    .neg_r (neg_r),
    .op    (op_q),
    .fixed (fixed)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= OP_MULT;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_q   <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state    <= state_nxt;
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q   <= op;
          neg_q  <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r  <= sgn_op & op[1] & a[WIDTH-1];
          zero_q <= op[1] && (b == '0);
          cnt    <= '0;
        end
        RUN: cnt <= cnt + CNT_W'(1);
        FIN: begin
          done     <= 1'b1;
          div_zero <= zero_q;
          if (!zero_q) {hi, lo} <= fixed;
        end
        default: ;
      endcase
    end
  end

  // Operand magnitudes and accumulator carry no reset; they are loaded on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      acc <= {{WIDTH{1'b0}}, mag(a, sgn_op)};
      opb <= mag(b, sgn_op);
    end else if (state == RUN) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a 64-bit arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start8;
  logic [1:0]  op, op8;
  logic [31:0] a, b, hi, lo;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy, done, div_zero, busy8, done8, div_zero8;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t dir[6];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division already truncates toward zero
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    sa = $signed(x);
    sb = $signed(y);
    ua = {32'd0, x};
    ub = {32'd0, y};
    exp_dz = 1'b0;
    case (o)
      OP_MULT:  begin p = sa * sb; {exp_hi, exp_lo} = p; end
      OP_MULTU: begin up = ua * ub; {exp_hi, exp_lo} = up; end
      OP_DIV: begin
        if (y == 0) exp_dz = 1'b1;
        else begin exp_lo = 32'(sa / sb); exp_hi = 32'(sa % sb); end
      end
      default: begin
        if (y == 0) exp_dz = 1'b1;
        else begin exp_lo = 32'(ua / ub); exp_hi = 32'(ua % ub); end
      end
    endcase
  endtask

  // Entered #1 after an edge with the unit idle or in its done cycle; returns in the done cycle
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit disturb);
    int n;
    int exp_lat;
    model(o, x, y);
    exp_lat = exp_dz ? 2 : 34;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 200) begin
      if (disturb && n == 4) begin
        start = 1'b1; op = OP_DIVU; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("latency", 64'(n + 1), 64'(exp_lat));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("div_zero", 64'(div_zero), 64'(exp_dz));
    chk("hi", 64'(hi), 64'(exp_hi));
    chk("lo", 64'(lo), 64'(exp_lo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1;
      3:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic seen;
    dir[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    dir[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    dir[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    dir[3] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
    dir[4] = '{OP_DIVU,  32'd5,         32'd0,        32'd2,         32'd14};
    dir[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};

    reset = 1'b1; start = 1'b0; op = OP_MULT; a = '0; b = '0;
    start8 = 1'b0; op8 = OP_MULT; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    chk("rst_hilo", 64'({hi, lo}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 8-bit instance: signed 0x80 * 0x80
    op8 = OP_MULT; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w8_latency", 64'(n + 1), 64'd10);
    chk("w8_hi", 64'(hi8), 64'h40);
    chk("w8_lo", 64'(lo8), 64'h00);

    foreach (dir[i]) begin
      run_op(dir[i].op, dir[i].a, dir[i].b, 1'b0);
      chk("dir_hi", 64'(hi), 64'(dir[i].hi));
      chk("dir_lo", 64'(lo), 64'(dir[i].lo));
    end

    run_op(OP_MULT, $urandom, $urandom, 1'b1);

    for (int i = 0; i < 150; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
    end

    // Reset asserted mid-operation, away from the clock edge
    op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_div_zero", 64'(div_zero), 64'd0);
    chk("midrst_hilo", 64'({hi, lo}), 64'd0);
    chk("midrst_hilo8", 64'({hi8, lo8}), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("no_done_after_reset", 64'(seen), 64'd0);

    run_op(OP_DIVU, 32'd5, 32'd0, 1'b0);
    run_op(OP_DIVU, $urandom, $urandom_range(1, 1000), 1'b0);
    run_op(OP_DIVU, $urandom, $urandom, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the multicycle CPU. It replaces the separate fixed 32-bit mult and div blocks with one shared datapath. It supports signed and unsigned multiply and divide on a start/done handshake, and holds results in internal HI/LO registers. The control FSM launches an operation and stalls until `done`, then reads `hi`/`lo` directly; HI/LO write-back muxing is no longer needed.

## Interface
- `WIDTH`, 32, operand/result width; legal values are even numbers ≥ 4.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request an operation; sampled only when the unit can accept.
- `op` in 2: operation code. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in WIDTH: multiplicand or dividend; sampled with `start`.
- `b` in WIDTH: multiplier or divisor; sampled with `start`.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse when the operation completes.
- `div_zero` out 1: one-cycle pulse coincident with `done` when DIV/DIVU has b == 0.
- `hi` out WIDTH: MULT high half, or DIV remainder.
- `lo` out WIDTH: MULT low half, or DIV quotient.

## Operation
- States: IDLE, RUN, FIN.
- Reset values: state IDLE; `busy`, `done`, `div_zero` 0; `hi`, `lo` 0; iteration counter 0.
- **IDLE** with `start`=1:
  - Latch `op`.
  - For signed ops, latch |a| and |b| and record the result sign(s).
  - DIV/DIVU with b==0: go directly to FIN with a zero flag set.
  - Otherwise: counter←0, go to RUN.
- **RUN**: one iteration per cycle, WIDTH iterations in total.
  - Multiply: radix-2 shift-add on a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - After iteration WIDTH−1, go to FIN.
- **FIN**, normal completion:
  - Apply sign correction.
  - Write `hi`/`lo`, pulse `done`, go to IDLE.
- **FIN**, zero-divide:
  - Pulse `done` and `div_zero`.
  - `hi`/`lo` keep their previous values.
- Signed multiply: the 2·WIDTH product is negated when the operand signs differ.
- Signed divide:
  - Quotient truncates toward zero and is negative when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - MIN / −1 gives quotient = MIN (wraps) and remainder 0, with no flag.
- Unsigned ops: operands are zero-extended and no sign correction is applied.
- `start` while `busy`=1 is ignored; the in-flight operation is undisturbed.
- `hi`/`lo` change only in a FIN cycle and otherwise hold indefinitely.
- Reset asserted mid-operation: the operation is abandoned immediately and all outputs return to their reset values.

## Timing
- Normal operation, with `start` sampled at edge 0:
  - RUN covers edges 1..WIDTH.
  - FIN is active between edges WIDTH and WIDTH+1.
  - `done`=1 in the cycle after edge WIDTH+1; the new `hi`/`lo` are visible in that same cycle.
- Latency is WIDTH+2 edges from acceptance to the cycle in which `done` is visible (34 for WIDTH=32).
- Zero-divide: FIN after edge 0; `done` and `div_zero` are high in the cycle after edge 1.
- `busy`:
  - Goes high after edge 0.
  - Drops together with the `done` rise, so `done` and `busy` are never both high.
- A new `start` in the `done` cycle is accepted at the next edge (back-to-back issue, no bubble).
- No combinational path from inputs to outputs.

## Structure
- Package `muldiv_pkg` holds:
  - the `op` code constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, RUN, FIN).
- Sub-module `muldiv_signfix` (combinational, parametrised by WIDTH) is the natural split. It takes {hi,lo} raw, the sign flags and the op, and returns the corrected {hi,lo}. It is shared by the multiply and divide paths.
- Everything else (counter, accumulators, FSM) lives in `muldiv_unit`.

## Test plan
All scenarios use WIDTH=32 unless stated.
- MULT a=0xFFFFFFFD (−3), b=5 → `done` at latency 34; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 → lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, `div_zero`=0.
- DIVU with b=0, preceded by a result hi=2/lo=14 → `done`+`div_zero` one cycle after the accept cycle; hi/lo stay 2/14.
- Pulse `start` with a different op at cycle 5 of a busy MULT → ignored; MULT result is unchanged.
- Assert `reset` at cycle 10 → all outputs 0 asynchronously; no `done` follows.
- WIDTH=8, MULT 0x80×0x80 → hi=0x40, lo=0x00 at latency 10.
- Back-to-back DIVU issued in the `done` cycle → second `done` exactly 34 cycles later.
